systolic_job_sched: RTL and testbench
=====================================

Name: systolic_job_sched

Overview:
- Shares one systolic_top matrix-multiply engine between NUM_REQ independent requesters.
- Arbitrates round-robin, registers the winner's A/B operands and pulses the engine start.
- Waits for the engine done with a watchdog, then returns C to the owning requester over a valid/ready response channel.
- Sits between DMA or host ports and the single systolic_top instance.

Parameters:
- NUM_REQ, 2, number of requesters.
- DATA_W, 8, operand element width (signed).
- ACC_W, 32, result element width (signed).
- ROWS, 4, rows of A and C.
- COLS, 4, columns of B and C.
- K, 4, inner dimension.
- TIMEOUT, 1024, maximum cycles spent in WAIT before a job is aborted.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester job request.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a_flat  in  NUM_REQ*ROWS*K*DATA_W  A operands; requester i occupies slice i.
- req_b_flat  in  NUM_REQ*K*COLS*DATA_W  B operands; requester i occupies slice i.
- resp_valid  out  NUM_REQ  per-requester result valid; one-hot or zero.
- resp_ready  in  NUM_REQ  per-requester result accept.
- resp_c_flat  out  ROWS*COLS*ACC_W  shared result bus, meaningful only while any resp_valid is high.
- resp_err  out  1  qualifies resp_valid; 1 = job timed out.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_busy  in  1  engine busy.
- eng_done  in  1  engine one-cycle done pulse.
- eng_a_flat  out  ROWS*K*DATA_W  registered A operand to the engine.
- eng_b_flat  out  K*COLS*DATA_W  registered B operand to the engine.
- eng_c_flat  in  ROWS*COLS*ACC_W  engine result.
- owner  out  clog2(NUM_REQ) (min 1)  requester owning the current job.
- jobs_done  out  16  count of completed jobs (ok or err); wraps at 16 bits.
- err_count  out  8  count of timed-out jobs; saturates at 255.

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - state=IDLE, rr_ptr=0, owner=0;
  - all outputs 0, including eng_a/b_flat, resp_c_flat, jobs_done and err_count.
- FSM IDLE:
  - Round-robin grant is combinational: the first requester with req_valid=1, searching from rr_ptr upward with wrap.
  - req_ready[g]=1 only for the granted g; all other req_ready bits are 0. No grant means req_ready=0.
  - On req_valid[g]&req_ready[g]: latch slice g of A/B into eng_a/b_flat, set owner=g, set rr_ptr=(g+1) mod NUM_REQ, go to LAUNCH.
- FSM LAUNCH:
  - If eng_busy=0: eng_start=1 for this cycle only, clear the watchdog, go to WAIT.
  - Otherwise hold in LAUNCH with eng_start=0. This covers an engine still running after a controller reset.
- FSM WAIT:
  - Watchdog increments every cycle.
  - On eng_done=1: capture eng_c_flat into resp_c_flat, resp_err=0, go to RESP.
  - Otherwise, when the watchdog reaches TIMEOUT-1: resp_c_flat=0, resp_err=1, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- FSM RESP:
  - resp_valid[owner]=1. resp_c_flat and resp_err are held stable until the handshake.
  - On resp_ready[owner]=1: increment jobs_done; increment err_count if resp_err (saturating at 255); go to IDLE. resp_valid drops the next cycle.
  - resp_ready of non-owners is ignored.
- eng_done is ignored outside WAIT (no stale capture).
- No new request is accepted outside IDLE; req_ready=0 in LAUNCH, WAIT and RESP.
- Minimum latency with an idle engine of latency L cycles start-to-done:
  - accept at cycle t;
  - eng_start at t+1;
  - eng_done at t+1+L;
  - resp_valid at t+2+L.
- Back-to-back: the earliest next accept is the cycle after the response handshake.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0.
- Operand slices are sampled only at accept. The requester may change them afterwards.

Decomposition:
- Shared package systolic_pkg: state enum (IDLE, LAUNCH, WAIT, RESP) and derived width constants (A_W, B_W, C_W, OWNER_W).
- One sub-module, rr_arbiter (NUM_REQ): inputs req, ptr; outputs a one-hot grant and its index.

Test Plan:
- Single job: requester 0 sends A=identity and B=1..16 row-major through a real systolic_top -> resp_valid[0] with C=1..16, resp_err=0, jobs_done=1.
- Contention: both requesters valid from the same cycle, each repeating 3 jobs -> grant order 0,1,0,1,0,1, and each response goes to the correct requester with the correct C.
- Backpressure: hold resp_ready[0]=0 for 20 cycles -> resp_valid and resp_c_flat stay stable, req_ready stays 0, and the handshake completes when resp_ready rises.
- Timeout: stub engine never asserts done, TIMEOUT=16 -> resp_valid 16 cycles after eng_start with resp_err=1, C=0, err_count=1, and the next job proceeds normally.
- Reset mid-WAIT: assert rst for 1 cycle while the engine is busy -> all outputs 0; a new request then holds in LAUNCH until eng_busy=0, and the late eng_done before the new start is ignored.
- Busy engine: eng_busy=1 at accept for 5 cycles -> eng_start fires exactly once, on the first cycle busy=0.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and width helpers for the systolic job scheduler.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int a_w(input int rows, input int k, input int data_w);
    return rows * k * data_w;
  endfunction

  function automatic int b_w(input int k, input int cols, input int data_w);
    return k * cols * data_w;
  endfunction

  function automatic int c_w(input int rows, input int cols, input int acc_w);
    return rows * cols * acc_w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping around.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    // Walk from the farthest offset to the nearest so the closest request wins.
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      idx = IDX_W'((int'(ptr) + j) % NUM_REQ);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  assign grant_vld = |req;

endmodule

// File: rtl/systolic_job_sched.sv
// Shares one systolic matrix engine between NUM_REQ requesters: round-robin
// accept, launch, watchdog-guarded wait, then valid/ready response to the owner.
module systolic_job_sched
  import systolic_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 32,
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int K       = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*ROWS*K*DATA_W-1:0]    req_a_flat,
  input  logic [NUM_REQ*K*COLS*DATA_W-1:0]    req_b_flat,
  output logic [NUM_REQ-1:0]                  resp_valid,
  input  logic [NUM_REQ-1:0]                  resp_ready,
  output logic [ROWS*COLS*ACC_W-1:0]          resp_c_flat,
  output logic                                resp_err,
  output logic                                eng_start,
  input  logic                                eng_busy,
  input  logic                                eng_done,
  output logic [ROWS*K*DATA_W-1:0]            eng_a_flat,
  output logic [K*COLS*DATA_W-1:0]            eng_b_flat,
  input  logic [ROWS*COLS*ACC_W-1:0]          eng_c_flat,
  output logic [owner_w(NUM_REQ)-1:0]         owner,
  output logic [15:0]                         jobs_done,
  output logic [7:0]                          err_count
);

  localparam int A_W     = a_w(ROWS, K, DATA_W);
  localparam int B_W     = b_w(K, COLS, DATA_W);
  localparam int C_W     = c_w(ROWS, COLS, ACC_W);
  localparam int OWNER_W = owner_w(NUM_REQ);
  localparam int WD_W    = $clog2(TIMEOUT) + 1;

  state_e             state_q, state_d;
  logic [OWNER_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [A_W-1:0]     eng_a_q, eng_a_d;
  logic [B_W-1:0]     eng_b_q, eng_b_d;
  logic [C_W-1:0]     resp_c_q, resp_c_d;
  logic               resp_err_q, resp_err_d;
  logic [WD_W-1:0]    wd_q, wd_d, wd_inc;
  logic [15:0]        jobs_done_q, jobs_done_d;
  logic [7:0]         err_count_q, err_count_d;

  logic [NUM_REQ-1:0] grant;
  logic [OWNER_W-1:0] grant_idx;
  logic               grant_vld;
  logic [A_W-1:0]     a_slice [NUM_REQ];
  logic [B_W-1:0]     b_slice [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign a_slice[i] = req_a_flat[i*A_W +: A_W];
    assign b_slice[i] = req_b_flat[i*B_W +: B_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (OWNER_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Ready is the grant itself, so an accept is simply any grant while idle.
  assign req_ready   = (state_q == IDLE) ? grant : '0;
  assign eng_start   = (state_q == LAUNCH) && !eng_busy;
  assign resp_valid  = (state_q == RESP) ? (NUM_REQ'(1) << owner_q) : '0;
  assign resp_c_flat = resp_c_q;
  assign resp_err    = resp_err_q;
  assign eng_a_flat  = eng_a_q;
  assign eng_b_flat  = eng_b_q;
  assign owner       = owner_q;
  assign jobs_done   = jobs_done_q;
  assign err_count   = err_count_q;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    eng_a_d     = eng_a_q;
    eng_b_d     = eng_b_q;
    resp_c_d    = resp_c_q;
    resp_err_d  = resp_err_q;
    wd_d        = wd_q;
    jobs_done_d = jobs_done_q;
    err_count_d = err_count_q;
    wd_inc      = wd_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          state_d  = LAUNCH;
          owner_d  = grant_idx;
          rr_ptr_d = (grant_idx == OWNER_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          eng_a_d  = a_slice[grant_idx];
          eng_b_d  = b_slice[grant_idx];
        end
      end
      LAUNCH: begin
        if (!eng_busy) begin
          state_d = WAIT;
          wd_d    = '0;
        end
      end
      WAIT: begin
        wd_d = wd_inc;
        // A done arriving on the timeout cycle still delivers a good result.
        if (eng_done) begin
          resp_c_d   = eng_c_flat;
          resp_err_d = 1'b0;
          state_d    = RESP;
        end else if (wd_inc == WD_W'(TIMEOUT - 1)) begin
          resp_c_d   = '0;
          resp_err_d = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (resp_ready[owner_q]) begin
          jobs_done_d = jobs_done_q + 16'd1;
          if (resp_err_q && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      eng_a_q     <= '0;
      eng_b_q     <= '0;
      resp_c_q    <= '0;
      resp_err_q  <= 1'b0;
      wd_q        <= '0;
      jobs_done_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      eng_a_q     <= eng_a_d;
      eng_b_q     <= eng_b_d;
      resp_c_q    <= resp_c_d;
      resp_err_q  <= resp_err_d;
      wd_q        <= wd_d;
      jobs_done_q <= jobs_done_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

// File: tb/tb_systolic_job_sched.sv
// Bench for systolic_job_sched: behavioural engine stub, per-cycle reference model, directed and random jobs.
module tb_systolic_job_sched;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 8;
  localparam int ACC_W   = 32;
  localparam int ROWS    = 4;
  localparam int COLS    = 4;
  localparam int K       = 4;
  localparam int TIMEOUT = 16;
  localparam int A_W     = ROWS * K * DATA_W;
  localparam int B_W     = K * COLS * DATA_W;
  localparam int C_W     = ROWS * COLS * ACC_W;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid, req_ready, resp_valid, resp_ready;
  logic [NUM_REQ*A_W-1:0]   req_a_flat;
  logic [NUM_REQ*B_W-1:0]   req_b_flat;
  logic [C_W-1:0]           resp_c_flat;
  logic                     resp_err, eng_start, eng_busy;
  logic                     eng_done = 1'b0;
  logic [C_W-1:0]           eng_c_flat = '0;
  logic [A_W-1:0]           eng_a_flat;
  logic [B_W-1:0]           eng_b_flat;
  logic [0:0]               owner;
  logic [15:0]              jobs_done;
  logic [7:0]               err_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_job_sched #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ACC_W(ACC_W),
    .ROWS(ROWS), .COLS(COLS), .K(K), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a_flat(req_a_flat), .req_b_flat(req_b_flat),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_c_flat(resp_c_flat), .resp_err(resp_err),
    .eng_start(eng_start), .eng_busy(eng_busy), .eng_done(eng_done),
    .eng_a_flat(eng_a_flat), .eng_b_flat(eng_b_flat), .eng_c_flat(eng_c_flat),
    .owner(owner), .jobs_done(jobs_done), .err_count(err_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic checkw(input string name, input logic [C_W-1:0] act, input logic [C_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [C_W-1:0] matmul(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    logic [C_W-1:0]           c;
    logic signed [DATA_W-1:0] ea, eb;
    longint                   s;
    c = '0;
    for (int r = 0; r < ROWS; r++)
      for (int cc = 0; cc < COLS; cc++) begin
        s = 0;
        for (int k = 0; k < K; k++) begin
          ea = a[(r*K + k)*DATA_W +: DATA_W];
          eb = b[(k*COLS + cc)*DATA_W +: DATA_W];
          s += longint'(ea) * longint'(eb);
        end
        c[(r*COLS + cc)*ACC_W +: ACC_W] = s[ACC_W-1:0];
      end
    return c;
  endfunction

  function automatic logic [A_W-1:0] rand_op();
    logic [A_W-1:0] v;
    for (int i = 0; i < A_W/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Engine stub: busy from the cycle after start, done pulse L cycles after start.
  int   eng_lat = 4;
  int   eng_rem = 0;
  logic eng_busy_stub = 1'b0;
  logic busy_force = 1'b0;
  logic eng_kill = 1'b0;
  assign eng_busy = eng_busy_stub | busy_force;

  always @(posedge clk) begin
    if (eng_kill) begin
      eng_rem <= 0; eng_busy_stub <= 1'b0; eng_done <= 1'b0;
    end else if (eng_start) begin
      eng_rem       <= eng_lat - 1;
      eng_busy_stub <= 1'b1;
      eng_done      <= (eng_lat == 1);
      eng_c_flat    <= matmul(eng_a_flat, eng_b_flat);
    end else if (eng_rem > 0) begin
      eng_rem  <= eng_rem - 1;
      eng_done <= (eng_rem == 1);
    end else begin
      eng_done      <= 1'b0;
      eng_busy_stub <= 1'b0;
    end
  end

  // Reference model: job ownership, round-robin pointer and timing from the rules.
  bit             m_active = 0, m_started = 0, m_resp = 0, m_err = 0;
  int             m_ptr = 0, m_owner = 0, m_start_cyc = 0, m_jobs = 0, m_errs = 0;
  logic [A_W-1:0] m_a = '0;
  logic [B_W-1:0] m_b = '0;
  logic [C_W-1:0] m_c = '0;
  int             grants[$];
  int             accept_cyc = 0, start_cyc = 0, start_cnt = 0, done_cyc = 0;

  always @(negedge clk) begin
    int                 g;
    logic [NUM_REQ-1:0] e_ready;
    g = -1;
    e_ready = '0;
    if (!m_active)
      for (int j = 0; j < NUM_REQ; j++)
        if (g < 0 && req_valid[(m_ptr + j) % NUM_REQ]) g = (m_ptr + j) % NUM_REQ;
    if (g >= 0) e_ready[g] = 1'b1;

    check("req_ready", 64'(req_ready), 64'(e_ready));
    check("eng_start", 64'(eng_start), 64'(m_active && !m_started && !eng_busy));
    check("resp_valid", 64'(resp_valid), m_resp ? (64'd1 << m_owner) : 64'd0);
    check("owner", 64'(owner), 64'(m_owner));
    check("jobs_done", 64'(jobs_done), 64'(m_jobs));
    check("err_count", 64'(err_count), 64'(m_errs));
    checkw("eng_a_flat", C_W'(eng_a_flat), C_W'(m_a));
    checkw("eng_b_flat", C_W'(eng_b_flat), C_W'(m_b));
    if (m_resp) begin
      checkw("resp_c_flat", resp_c_flat, m_c);
      check("resp_err", 64'(resp_err), 64'(m_err));
    end

    if ((req_valid & req_ready) != '0) begin
      grants.push_back(int'(req_ready[1]));
      accept_cyc = cyc;
    end
    if (eng_start) begin
      start_cyc = cyc;
      start_cnt++;
    end
    if (eng_done) done_cyc = cyc;

    if (rst) begin
      m_active = 0; m_started = 0; m_resp = 0; m_err = 0;
      m_ptr = 0; m_owner = 0; m_jobs = 0; m_errs = 0;
      m_a = '0; m_b = '0; m_c = '0;
    end else if (!m_active) begin
      if (g >= 0) begin
        m_active = 1; m_started = 0; m_resp = 0;
        m_owner = g; m_ptr = (g + 1) % NUM_REQ;
        m_a = req_a_flat[g*A_W +: A_W];
        m_b = req_b_flat[g*B_W +: B_W];
      end
    end else if (!m_started) begin
      if (!eng_busy) begin
        m_started = 1; m_start_cyc = cyc;
      end
    end else if (!m_resp) begin
      if (eng_done) begin
        m_resp = 1; m_err = 0; m_c = matmul(m_a, m_b);
      end else if (cyc - m_start_cyc == TIMEOUT - 1) begin
        m_resp = 1; m_err = 1; m_c = '0;
      end
    end else if (resp_ready[m_owner]) begin
      m_jobs = (m_jobs + 1) % 65536;
      if (m_err && m_errs < 255) m_errs++;
      m_active = 0; m_started = 0; m_resp = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(input int who, input int limit);
    bit ok;
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      if (resp_valid[who]) begin
        ok = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_resp%0d: no resp_valid within %0d cycles, required one", who, limit);
    end
  endtask

  task automatic set_ops(input int who, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    req_a_flat[who*A_W +: A_W] = a;
    req_b_flat[who*B_W +: B_W] = b;
  endtask

  task automatic check_all_zero(input string name);
    checkw(name, C_W'({req_ready, resp_valid, resp_err, eng_start, owner, jobs_done, err_count}), '0);
    checkw({name, "_c"}, resp_c_flat, '0);
    checkw({name, "_ab"}, C_W'({eng_a_flat, eng_b_flat}), '0);
  endtask

  logic [A_W-1:0] a_id, a_tmp;
  logic [B_W-1:0] b_seq, b_tmp;
  logic [C_W-1:0] c_lit, c_hold;
  int             s0, rel;

  initial begin
    rst = 1'b1; req_valid = '0; resp_ready = '0; req_a_flat = '0; req_b_flat = '0;
    repeat (2) tick();
    check_all_zero("reset");
    rst = 1'b0;

    // Single job: identity times 1..16 must give back 1..16.
    a_id = '0; b_seq = '0; c_lit = '0;
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < K; k++) a_id[(r*K + k)*DATA_W +: DATA_W] = (r == k) ? 8'd1 : 8'd0;
    for (int i = 0; i < K*COLS; i++) b_seq[i*DATA_W +: DATA_W] = 8'(i + 1);
    for (int i = 0; i < ROWS*COLS; i++) c_lit[i*ACC_W +: ACC_W] = 32'(i + 1);
    set_ops(0, a_id, b_seq);
    set_ops(1, rand_op(), rand_op());
    eng_lat = 4;
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    wait_resp(0, 50);
    checkw("single_c", resp_c_flat, c_lit);
    check("single_err", 64'(resp_err), 64'd0);
    check("single_latency", 64'(cyc - accept_cyc), 64'd6);
    resp_ready = 2'b01;
    tick();
    resp_ready = '0;
    check("single_jobs", 64'(jobs_done), 64'd1);

    // Contention: both requesters continuously valid from a fresh pointer.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    grants.delete();
    eng_lat = 3;
    resp_ready = 2'b11;
    req_valid = 2'b11;
    for (int i = 0; i < 300 && grants.size() < 6; i++) begin
      set_ops(0, rand_op(), rand_op());
      set_ops(1, rand_op(), rand_op());
      tick();
    end
    req_valid = '0;
    for (int i = 0; i < 50 && jobs_done != 16'd6; i++) tick();
    check("contention_jobs", 64'(jobs_done), 64'd6);
    check("contention_ngrants", 64'(grants.size()), 64'd6);
    for (int i = 0; i < 6 && i < grants.size(); i++)
      check($sformatf("grant_order%0d", i), 64'(grants[i]), 64'(i % 2));
    resp_ready = '0;

    // Backpressure: result must hold while the owner stalls; requester 1 must wait.
    eng_lat = 2;
    set_ops(0, rand_op(), rand_op());
    req_valid = 2'b01;
    tick();
    req_valid = 2'b10;
    wait_resp(0, 50);
    c_hold = resp_c_flat;
    for (int i = 0; i < 20; i++) begin
      tick();
      checkw("bp_c_stable", resp_c_flat, c_hold);
      check("bp_hold", 64'({resp_valid, req_ready}), 64'b0100);
    end
    resp_ready = 2'b10;
    tick();
    check("bp_non_owner_ignored", 64'(resp_valid), 64'b01);
    resp_ready = 2'b01;
    tick();
    check("bp_next_accept", 64'({resp_valid, req_ready}), 64'b0010);
    resp_ready = 2'b11;
    tick();
    req_valid = '0;
    for (int i = 0; i < 30 && m_active; i++) tick();
    resp_ready = '0;

    // Timeout: engine never finishes.
    eng_lat = 100000;
    set_ops(1, rand_op(), rand_op());
    req_valid = 2'b10;
    tick();
    req_valid = '0;
    wait_resp(1, 100);
    check("to_latency", 64'(cyc - start_cyc), 64'(TIMEOUT));
    check("to_err", 64'(resp_err), 64'd1);
    checkw("to_c", resp_c_flat, '0);
    resp_ready = 2'b10;
    tick();
    resp_ready = '0;
    check("to_err_count", 64'(err_count), 64'd1);
    eng_kill = 1'b1;
    tick();
    eng_kill = 1'b0;

    // Done on the last watchdog cycle wins over timeout.
    eng_lat = TIMEOUT - 1;
    a_tmp = rand_op();
    b_tmp = rand_op();
    set_ops(0, a_tmp, b_tmp);
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    wait_resp(0, 100);
    check("edge_latency", 64'(cyc - start_cyc), 64'(TIMEOUT));
    check("edge_err", 64'(resp_err), 64'd0);
    checkw("edge_c", resp_c_flat, matmul(a_tmp, b_tmp));
    resp_ready = 2'b01;
    tick();
    resp_ready = '0;
    check("edge_err_count", 64'(err_count), 64'd1);

    // Reset while the engine is mid-job; the late done must be ignored.
    eng_lat = 12;
    set_ops(0, rand_op(), rand_op());
    req_valid = 2'b01;
    s0 = start_cnt;
    tick();
    req_valid = '0;
    for (int i = 0; i < 10 && start_cnt == s0; i++) tick();
    eng_lat = 4;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check_all_zero("mid_reset");
    check("mid_reset_busy", 64'(eng_busy), 64'd1);
    rst = 1'b0;
    set_ops(0, rand_op(), rand_op());
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    s0 = start_cnt;
    for (int i = 0; i < 40 && start_cnt == s0; i++) tick();
    check("mid_reset_started", 64'(start_cnt - s0), 64'd1);
    check("mid_reset_done_in_launch", 64'(done_cyc > accept_cyc && start_cyc > done_cyc), 64'd1);
    wait_resp(0, 50);
    resp_ready = 2'b01;
    tick();
    resp_ready = '0;

    // Busy engine at accept: start exactly once, on the first non-busy cycle.
    eng_lat = 3;
    set_ops(1, rand_op(), rand_op());
    s0 = start_cnt;
    req_valid = 2'b10;
    busy_force = 1'b1;
    tick();
    req_valid = '0;
    repeat (4) tick();
    busy_force = 1'b0;
    rel = cyc;
    wait_resp(1, 50);
    check("busy_start_count", 64'(start_cnt - s0), 64'd1);
    check("busy_start_cycle", 64'(start_cyc), 64'(rel));
    resp_ready = 2'b10;
    tick();
    resp_ready = '0;

    // Random traffic: latencies straddle the watchdog limit.
    for (int i = 0; i < 600; i++) begin
      req_valid  = NUM_REQ'($urandom);
      resp_ready = NUM_REQ'($urandom);
      set_ops(0, rand_op(), rand_op());
      set_ops(1, rand_op(), rand_op());
      eng_lat = $urandom_range(1, 18);
      tick();
    end
    req_valid = '0;
    resp_ready = 2'b11;
    repeat (60) tick();
    check("drain_idle", 64'(resp_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
